// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the memory read server slice:
//   - mrs_state_t        : responder FSM state encoding
//   - MRS_ERR_DATA_DEFAULT: word returned for out-of-range reads
//   - mrs_cnt_width()    : width helper for the delay/latency counters
package mem_bus_pkg;

  typedef enum logic [2:0] {
    MRS_IDLE   = 3'd0,
    MRS_ARB    = 3'd1,
    MRS_GRANT  = 3'd2,
    MRS_ACCESS = 3'd3,
    MRS_DATA   = 3'd4
  } mrs_state_t;

  localparam logic [31:0] MRS_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width able to hold any value 0..max(d,1) without wrapping.
  function automatic int mrs_cnt_width(input int d);
    return $clog2((d < 1) ? 1 : d) + 1;
  endfunction

endpackage

// File: rtl/mem_read_server_if.sv
// mem_read_server_if
//   Task-level read handshake between a bus master and the memory-side
//   responder.
//   Signals:
//     read_request (master->slave) level read request
//     addr_bus     (master->slave) read address, valid while read_grant=1
//     read_grant   (slave->master) one-cycle grant per transaction
//     data_bus     (slave->master) returned word, 0 when data_valid=0
//     data_valid   (slave->master) data_bus holds the returned word
//     addr_err     (slave->master) returned word is the error word
//     busy         (slave->master) responder is not idle
interface mem_read_server_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic              read_request;
  logic [ADDR_W-1:0] addr_bus;
  logic              read_grant;
  logic [DATA_W-1:0] data_bus;
  logic              data_valid;
  logic              addr_err;
  logic              busy;

  modport master (
    output read_request, addr_bus,
    input  read_grant, data_bus, data_valid, addr_err, busy
  );

  modport slave (
    input  read_request, addr_bus,
    output read_grant, data_bus, data_valid, addr_err, busy
  );

endinterface

// File: rtl/mem_read_store.sv
// mem_read_store
//   DEPTH x DATA_W word store with one write port and one registered
//   read port (data appears one edge after rd_en). Addresses are assumed
//   in range; the parent filters out-of-range accesses.
//   Ports:
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write word index
//     wr_data  in   write data
//     rd_en    in   read strobe
//     rd_addr  in   read word index
//     rd_data  out  registered read data
module mem_read_store #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Both ports update on the same edge with non-blocking assignments, so a
  // read colliding with a write to the same word returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/mem_read_server.sv
// mem_read_server
//   Memory-side responder for the read handshake. Serves one read at a
//   time: waits GRANT_DELAY cycles, grants for one cycle while capturing
//   the address, waits READ_LATENCY cycles, then presents the word until
//   the master drops read_request. Out-of-range addresses return ERR_DATA
//   with addr_err set. The local store has an independent write port.
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset
//     bus      slave modport of mem_read_server_if
//     wr_en    in   store write strobe
//     wr_addr  in   store write address (ignored if >= DEPTH)
//     wr_data  in   store write data
module mem_read_server
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 1024,
  parameter int                GRANT_DELAY  = 1,
  parameter int                READ_LATENCY = 2,
  parameter logic [DATA_W-1:0] ERR_DATA     = MRS_ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_read_server_if.slave  bus,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int GW = mrs_cnt_width(GRANT_DELAY);
  localparam int LW = mrs_cnt_width(READ_LATENCY);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  mrs_state_t        state_q, state_d;
  logic [GW-1:0]     arb_cnt_q, arb_cnt_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              rd_oob;
  logic              wr_ok;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  // Full-width unsigned range checks.
  assign rd_oob = ({1'b0, addr_q} >= DEPTH_L);
  assign wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_L);

  mem_read_store #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    arb_cnt_d = arb_cnt_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    case (state_q)
      MRS_IDLE: begin
        // Reaching IDLE always involves seeing the request low, so a
        // request held through the previous transaction cannot restart it.
        if (bus.read_request) begin
          if (GRANT_DELAY == 0) begin
            state_d = MRS_GRANT;
          end else begin
            state_d   = MRS_ARB;
            arb_cnt_d = GW'(GRANT_DELAY - 1);
          end
        end
      end
      MRS_ARB: begin
        if (!bus.read_request) begin
          state_d = MRS_IDLE;
        end else if (arb_cnt_q == '0) begin
          state_d = MRS_GRANT;
        end else begin
          arb_cnt_d = arb_cnt_q - GW'(1);
        end
      end
      MRS_GRANT: begin
        if (!bus.read_request) begin
          state_d = MRS_IDLE;
        end else begin
          addr_d    = bus.addr_bus;
          lat_cnt_d = LW'(READ_LATENCY - 1);
          drop_d    = 1'b0;
          state_d   = MRS_ACCESS;
        end
      end
      MRS_ACCESS: begin
        // A drop during the access is remembered; the access still runs to
        // completion but nothing is presented.
        if (!bus.read_request) begin
          drop_d = 1'b1;
        end
        if (lat_cnt_q == '0) begin
          rd_en = !rd_oob;
          if (drop_q || !bus.read_request) begin
            state_d = MRS_IDLE;
          end else begin
            state_d = MRS_DATA;
            valid_d = 1'b1;
            err_d   = rd_oob;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      MRS_DATA: begin
        if (!bus.read_request) begin
          state_d = MRS_IDLE;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = MRS_IDLE;
        valid_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MRS_IDLE;
      arb_cnt_q <= '0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_cnt_q <= arb_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // The store's read register has no reset; gating by valid_q makes
  // data_bus drop to 0 the instant reset asserts.
  assign bus.data_bus   = valid_q ? (err_q ? ERR_DATA : rd_data) : '0;
  assign bus.data_valid = valid_q;
  assign bus.addr_err   = err_q;
  assign bus.read_grant = (state_q == MRS_GRANT);
  assign bus.busy       = (state_q != MRS_IDLE);

endmodule

// File: tb/tb_mem_read_server.sv
// tb_mem_read_server
//   Directed bench for mem_read_server. Two instances share clock, reset
//   and the store write port: bus1 runs GRANT_DELAY=1, bus0 GRANT_DELAY=0,
//   both with READ_LATENCY=2 and DEPTH=1024.
module tb_mem_read_server;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  int compared   = 0;
  int mismatched = 0;

  int grantCnt1 = 0;
  int dvRise1   = 0;
  int grantCnt0 = 0;
  logic dvPrev1 = 1'b0;

  mem_read_server_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();
  mem_read_server_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();

  mem_read_server #(
    .ADDR_W(16), .DATA_W(32), .DEPTH(1024),
    .GRANT_DELAY(1), .READ_LATENCY(2), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  mem_read_server #(
    .ADDR_W(16), .DATA_W(32), .DEPTH(1024),
    .GRANT_DELAY(0), .READ_LATENCY(2), .ERR_DATA(32'hDEAD_BEEF)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant and data_valid rise tallies, sampled mid-cycle.
  always @(negedge clk) begin
    grantCnt1 = grantCnt1 + int'(bus1.read_grant);
    grantCnt0 = grantCnt0 + int'(bus0.read_grant);
    if (bus1.data_valid && !dvPrev1) dvRise1 = dvRise1 + 1;
    dvPrev1 = bus1.data_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [15:0] addr);
    bus1.read_request = req;
    bus1.addr_bus     = addr;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic writeWord(input logic [15:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Full read on bus1; lat counts edges from request until data_valid.
  task automatic readWord(input logic [15:0] a, output logic [31:0] d,
                          output logic err, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    d    = '0;
    err  = 1'b0;
    applyStimulus(1'b1, a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus1.data_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("readNoTimeout", {31'd0, seen}, 32'd1);
    d   = bus1.data_bus;
    err = bus1.addr_err;
    applyStimulus(1'b0, 16'h0);
    @(negedge clk);
  endtask

  logic [31:0] rdData;
  logic        rdErr;
  int          rdLat;
  int          g0;
  int          dv0;

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    applyStimulus(1'b0, 16'h0);
    bus0.read_request = 1'b0;
    bus0.addr_bus     = 16'h0;
    #12;
    $display("[TB] reset checks");
    checkOutput("rstGrant", {31'd0, bus1.read_grant}, 32'd0);
    checkOutput("rstValid", {31'd0, bus1.data_valid}, 32'd0);
    checkOutput("rstBusy",  {31'd0, bus1.busy}, 32'd0);
    checkOutput("rstData",  bus1.data_bus, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    writeWord(16'd5, 32'h1234_5678);
    writeWord(16'd9, 32'h0000_000A);

    // Test 1: exact timing of a basic read.
    $display("[TB] basic read timing");
    applyStimulus(1'b1, 16'd5);
    @(negedge clk);
    checkOutput("t1E0Grant", {31'd0, bus1.read_grant}, 32'd0);
    checkOutput("t1E0Busy",  {31'd0, bus1.busy}, 32'd1);
    @(negedge clk);
    checkOutput("t1E1Grant", {31'd0, bus1.read_grant}, 32'd1);
    @(negedge clk);
    checkOutput("t1E2Grant", {31'd0, bus1.read_grant}, 32'd0);
    @(negedge clk);
    checkOutput("t1E3Valid", {31'd0, bus1.data_valid}, 32'd0);
    @(negedge clk);
    checkOutput("t1E4Valid", {31'd0, bus1.data_valid}, 32'd1);
    checkOutput("t1E4Data",  bus1.data_bus, 32'h1234_5678);
    checkOutput("t1E4Err",   {31'd0, bus1.addr_err}, 32'd0);
    cycles(2);
    checkOutput("t1E6Data",  bus1.data_bus, 32'h1234_5678);
    applyStimulus(1'b0, 16'd0);
    @(negedge clk);
    checkOutput("t1E7Valid", {31'd0, bus1.data_valid}, 32'd0);
    checkOutput("t1E7Data",  bus1.data_bus, 32'd0);
    checkOutput("t1E7Busy",  {31'd0, bus1.busy}, 32'd0);

    // Test 2: out-of-range address.
    $display("[TB] out-of-range read");
    readWord(16'h0400, rdData, rdErr, rdLat);
    checkOutput("t2Data", rdData, 32'hDEAD_BEEF);
    checkOutput("t2Err",  {31'd0, rdErr}, 32'd1);
    checkOutput("t2Lat",  rdLat, 32'd5);
    readWord(16'hFFFF, rdData, rdErr, rdLat);
    checkOutput("t2MaxErr", {31'd0, rdErr}, 32'd1);
    readWord(16'd1023, rdData, rdErr, rdLat);
    checkOutput("t2LastErr", {31'd0, rdErr}, 32'd0);

    // Test 3a: abort in ARB.
    $display("[TB] abort in ARB");
    g0 = grantCnt1;
    applyStimulus(1'b1, 16'd5);
    @(negedge clk);
    applyStimulus(1'b0, 16'd5);
    @(negedge clk);
    checkOutput("t3aBusy", {31'd0, bus1.busy}, 32'd0);
    cycles(3);
    checkOutput("t3aGrants", grantCnt1 - g0, 32'd0);

    // Test 3b: abort in ACCESS.
    $display("[TB] abort in ACCESS");
    dv0 = dvRise1;
    applyStimulus(1'b1, 16'd5);
    cycles(3);
    applyStimulus(1'b0, 16'd5);
    @(negedge clk);
    checkOutput("t3bBusyMid", {31'd0, bus1.busy}, 32'd1);
    @(negedge clk);
    checkOutput("t3bBusyEnd", {31'd0, bus1.busy}, 32'd0);
    cycles(3);
    checkOutput("t3bNoValid", dvRise1 - dv0, 32'd0);

    // Test 4: write lands on the final ACCESS edge of a read to the same word.
    $display("[TB] read/write collision");
    applyStimulus(1'b1, 16'd9);
    cycles(4);
    wr_en = 1'b1; wr_addr = 16'd9; wr_data = 32'h0000_000B;
    @(negedge clk);
    wr_en = 1'b0;
    checkOutput("t4Valid", {31'd0, bus1.data_valid}, 32'd1);
    checkOutput("t4Old",   bus1.data_bus, 32'h0000_000A);
    applyStimulus(1'b0, 16'd0);
    @(negedge clk);
    readWord(16'd9, rdData, rdErr, rdLat);
    checkOutput("t4New", rdData, 32'h0000_000B);

    // Test 5: request held high across what would be two reads.
    $display("[TB] held request");
    g0 = grantCnt1;
    applyStimulus(1'b1, 16'd5);
    cycles(12);
    checkOutput("t5OneGrant", grantCnt1 - g0, 32'd1);
    checkOutput("t5Held",     {31'd0, bus1.data_valid}, 32'd1);
    applyStimulus(1'b0, 16'd5);
    @(negedge clk);
    applyStimulus(1'b1, 16'd5);
    cycles(6);
    checkOutput("t5TwoGrants", grantCnt1 - g0, 32'd2);
    checkOutput("t5Data2",     bus1.data_bus, 32'h1234_5678);
    applyStimulus(1'b0, 16'd0);
    @(negedge clk);

    // Test 5b: zero grant delay.
    $display("[TB] zero grant delay");
    bus0.read_request = 1'b1;
    bus0.addr_bus     = 16'd5;
    @(negedge clk);
    checkOutput("t5bGrant",  {31'd0, bus0.read_grant}, 32'd1);
    @(negedge clk);
    checkOutput("t5bGrantOff", {31'd0, bus0.read_grant}, 32'd0);
    @(negedge clk);
    checkOutput("t5bE2Valid", {31'd0, bus0.data_valid}, 32'd0);
    @(negedge clk);
    checkOutput("t5bE3Valid", {31'd0, bus0.data_valid}, 32'd1);
    checkOutput("t5bData",    bus0.data_bus, 32'h1234_5678);

    // Test 6: asynchronous reset while in DATA.
    $display("[TB] async reset in DATA");
    applyStimulus(1'b1, 16'd9);
    cycles(5);
    checkOutput("t6PreValid", {31'd0, bus1.data_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6Valid",  {31'd0, bus1.data_valid}, 32'd0);
    checkOutput("t6Data",   bus1.data_bus, 32'd0);
    checkOutput("t6Busy",   {31'd0, bus1.busy}, 32'd0);
    checkOutput("t6Err",    {31'd0, bus1.addr_err}, 32'd0);
    checkOutput("t6Valid0", {31'd0, bus0.data_valid}, 32'd0);
    checkOutput("t6Data0",  bus0.data_bus, 32'd0);
    applyStimulus(1'b0, 16'd0);
    bus0.read_request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    checkOutput("t6IdleBusy",  {31'd0, bus1.busy}, 32'd0);
    checkOutput("t6IdleGrant", {31'd0, bus1.read_grant}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_read_server.md
Name: mem_read_server

Overview:
- Memory-side responder for the task-level read handshake (read_request / read_grant / addr_bus / data_bus) driven by the bus-master read tasks.
- Accepts one read at a time: arbitrates (fixed grant delay), captures the address, waits a fixed access latency, then returns a data word.
- Holds the word until the master drops read_request.
- Owns a local word-addressed store with an independent preload/write port.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 32, data bus width.
- DEPTH, 1024, number of words in the store; valid addresses are 0..DEPTH-1.
- GRANT_DELAY, 1, cycles from request acceptance to grant (0 allowed).
- READ_LATENCY, 2, cycles from address capture to data valid (min 1).
- ERR_DATA, 32'hDEAD_BEEF, word returned for an out-of-range address.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- read_request  in  1  master read request, level.
- addr_bus  in  ADDR_W  read address; sampled only while read_grant=1.
- read_grant  out  1  grant; high exactly one cycle per transaction.
- data_bus  out  DATA_W  read data; 0 when data_valid=0.
- data_valid  out  1  data_bus holds the returned word.
- addr_err  out  1  qualifies data_valid; 1 = address out of range.
- busy  out  1  state is not IDLE.
- wr_en  in  1  store write strobe.
- wr_addr  in  ADDR_W  store write address.
- wr_data  in  DATA_W  store write data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - read_grant, data_valid, addr_err, busy all 0; data_bus=0.
  - Counters are cleared; store contents are undefined.
  - Reset asserted mid-transaction aborts the transaction immediately; no data is returned.
- FSM states: IDLE, ARB, GRANT, ACCESS, DATA.
- IDLE:
  - read_request=1 at an edge: go to ARB with delay counter = GRANT_DELAY-1.
  - If GRANT_DELAY=0, go straight to GRANT.
- ARB: counts down; at 0 go to GRANT.
- GRANT:
  - read_grant=1 for this one cycle.
  - At the closing edge, capture addr_bus, load the latency counter with READ_LATENCY-1, go to ACCESS.
- ACCESS:
  - Counts down.
  - On the last cycle, issue the store read (or select ERR_DATA if addr >= DEPTH).
  - At the closing edge, register data_bus and set data_valid=1 and addr_err.
  - Go to DATA.
- DATA:
  - Holds data_bus / data_valid / addr_err stable while read_request=1.
  - When read_request=0 at an edge: go to IDLE and clear data_valid, addr_err and data_bus.
- Timing, with request first sampled high at edge E:
  - grant is high in the cycle after edge E+GRANT_DELAY.
  - address is captured at edge E+GRANT_DELAY+1.
  - data_valid rises after edge E+GRANT_DELAY+1+READ_LATENCY.
- Abort:
  - read_request=0 at an edge in ARB or GRANT: return to IDLE; no capture, no data.
  - Dropping in GRANT suppresses the capture.
  - read_request=0 during ACCESS: access completes silently; go to IDLE with data_valid kept 0.
- Back-to-back: IDLE needs at least one cycle with read_request=0. A request held high through DATA→IDLE does not start a new transaction until it has been observed low.
- Write port:
  - Active in every state.
  - Writes with wr_addr >= DEPTH are ignored.
  - Write and read to the same address on the same edge: the read returns the old word (read-before-write).
  - Writes before the read edge are visible.
- busy = (state != IDLE).
- Counters are sized $clog2(max(delay,1))+1; no wrap is possible.
- Addresses are compared unsigned, full ADDR_W width.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum mrs_state_t;
  - the default ERR_DATA constant;
  - localparam helpers for counter widths.
- One sub-module, mem_read_store:
  - synchronous DEPTH x DATA_W array;
  - write port plus registered read port (1-cycle);
  - range check done in the parent.

Test Plan:
1. Preload addr 5 = 32'h1234_5678; GRANT_DELAY=1, READ_LATENCY=2; raise request at edge 0 with addr 5.
   Required: grant high in cycle 1 only; data_valid rises after edge 4 with data 32'h1234_5678 and addr_err=0; request low at edge 7 → data_valid=0, data_bus=0 after edge 7.
2. Read addr 16'h0400 (DEPTH=1024).
   Required: data_bus=32'hDEAD_BEEF, addr_err=1.
3. Abort: drop request in ARB.
   Required: read_grant never high, busy=0 next cycle.
   Repeat by dropping request in ACCESS.
   Required: data_valid never rises; FSM returns to IDLE.
4. Collision: addr 9 = 32'hA; read addr 9 while a write of 32'hB to addr 9 lands on the final ACCESS edge.
   Required: returns 32'hA; an immediate second read returns 32'hB.
5. Request held high continuously across two reads.
   Required: only one grant; after request drops one cycle and rises again, a second grant follows.
   Also with GRANT_DELAY=0: grant in the cycle right after request sampled.
6. Assert rst_n=0 asynchronously in DATA.
   Required: all outputs 0 immediately without a clock edge; after release with request low, the FSM is in IDLE.
